// File: rtl/cnt_share_arbiter.sv
// cnt_share_arbiter
// Round-robin arbiter that lends one shared WIDTH-bit down-counter to NREQ
// requesters. The winner loads its own value and owns the counter until the
// count reaches zero (done pulse), it drops its request (abort), or reset.
//
// Optional feature: define CNT_ARB_HOLD_EN to add a 1-bit `hold` input that
// freezes a running count. The default build (macro undefined) behaves as if
// hold were tied low and has no such port.
module cnt_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef CNT_ARB_HOLD_EN
  input  logic                      hold,
`endif
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_val,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [WIDTH-1:0]          cnt_out,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q,   gnt_d;
  logic [WIDTH-1:0]   cnt_q,   cnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q,   ptr_d;

  logic               hold_w;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [WIDTH-1:0]   win_val;

`ifdef CNT_ARB_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Round-robin search: first set request bit starting just above ptr, wrapping.
  always_comb begin
    int idx;
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  assign win_val = req_val[int'(win_idx)*WIDTH +: WIDTH];

  // Next-state and next-register values for the three-state run controller.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
          ptr_d   = win_idx;
          cnt_d   = win_val;
          state_d = (win_val != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (!req[owner_q]) begin
          // Owner withdrew: release without a done pulse, ptr stays put.
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (hold_w) begin
          state_d = COUNT;
        end else if (cnt_q <= WIDTH'(1)) begin
          // Final step to zero; the <= also guards against wrapping below 0.
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous active-high reset that overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = (state_q == DONE) ? gnt_q : '0;
  assign cnt_out = cnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_cnt_share_arbiter.sv
// Directed self-checking bench for cnt_share_arbiter (NREQ=4, WIDTH=5).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cnt_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  hold;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_val;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      cnt_out;
  logic [1:0]            owner;
  logic                  busy;

  int tests = 0;
  int fails = 0;

  cnt_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef CNT_ARB_HOLD_EN
    .hold    (hold),
`endif
    .req     (req),
    .req_val (req_val),
    .gnt     (gnt),
    .done    (done),
    .cnt_out (cnt_out),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_val(input int i, input logic [WIDTH-1:0] v);
    req_val[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    hold  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; hold = 1'b0; req_val = '0;
    tick(); tick();
    tests++;
    if ({gnt, done, cnt_out, owner, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b done=%b cnt=%0d owner=%0d busy=%b, want all 0",
               gnt, done, cnt_out, owner, busy);
    end
    reset = 1'b0;
  endtask

  // req=0001, val0=3: cnt 3,2,1,0 with done at 0, then idle.
  task automatic test_single();
    logic [WIDTH-1:0] exp_cnt [4];
    exp_cnt = '{5'd3, 5'd2, 5'd1, 5'd0};
    do_reset();
    set_val(0, 5'd3);
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (gnt !== 4'b0001 || cnt_out !== exp_cnt[c] || busy !== 1'b1 ||
          done !== ((c == 3) ? 4'b0001 : 4'b0000)) begin
        fails++;
        $display("FAIL single_cycle%0d: got gnt=%b cnt=%0d done=%b busy=%b, want gnt=0001 cnt=%0d done=%b busy=1",
                 c, gnt, cnt_out, done, busy, exp_cnt[c], (c == 3) ? 4'b0001 : 4'b0000);
      end
    end
    req = '0;
    tick();
    tests++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000 || cnt_out !== 5'd0) begin
      fails++;
      $display("FAIL single_idle: got busy=%b gnt=%b done=%b cnt=%0d, want 0 0000 0000 0",
               busy, gnt, done, cnt_out);
    end
  endtask

  // req=1111 with all values 1: grants 0,1,2,3,0; each run 2 cycles + 1 idle.
  task automatic test_round_robin();
    logic [NREQ-1:0] w_oh;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_val(i, 5'd1);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      w_oh = 4'b0001 << (r % NREQ);
      tick();
      tests++;
      if (gnt !== w_oh || owner !== 2'(r % NREQ) || cnt_out !== 5'd1 || done !== 4'b0000) begin
        fails++;
        $display("FAIL rr_grant%0d: got gnt=%b owner=%0d cnt=%0d done=%b, want gnt=%b owner=%0d cnt=1 done=0000",
                 r, gnt, owner, cnt_out, done, w_oh, r % NREQ);
      end
      tick();
      tests++;
      if (gnt !== w_oh || done !== w_oh || cnt_out !== 5'd0) begin
        fails++;
        $display("FAIL rr_done%0d: got gnt=%b done=%b cnt=%0d, want gnt=%b done=%b cnt=0",
                 r, gnt, done, cnt_out, w_oh, w_oh);
      end
      tick();
      tests++;
      if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000) begin
        fails++;
        $display("FAIL rr_idle%0d: got busy=%b gnt=%b done=%b, want 0 0000 0000", r, busy, gnt, done);
      end
    end
    req = '0;
    tick();
  endtask

  // req=0100 with val2=0: grant and done in the same cycle, then idle.
  task automatic test_zero_load();
    do_reset();
    set_val(2, 5'd0);
    req = 4'b0100;
    tick();
    tests++;
    if (gnt !== 4'b0100 || done !== 4'b0100 || cnt_out !== 5'd0 || owner !== 2'd2 || busy !== 1'b1) begin
      fails++;
      $display("FAIL zero_grant_done: got gnt=%b done=%b cnt=%0d owner=%0d busy=%b, want 0100 0100 0 2 1",
               gnt, done, cnt_out, owner, busy);
    end
    req = '0;
    tick();
    tests++;
    if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_idle: got gnt=%b done=%b busy=%b, want 0000 0000 0", gnt, done, busy);
    end
  endtask

  // Grant 1 with val 10, drop req[1] at cnt=6: abort without done, then 0011 grants 0.
  task automatic test_abort();
    do_reset();
    set_val(1, 5'd10);
    set_val(0, 5'd7);
    req = 4'b0010;
    tick();
    tests++;
    if (gnt !== 4'b0010 || cnt_out !== 5'd10 || owner !== 2'd1) begin
      fails++;
      $display("FAIL abort_grant: got gnt=%b cnt=%0d owner=%0d, want 0010 10 1", gnt, cnt_out, owner);
    end
    repeat (4) tick();
    tests++;
    if (cnt_out !== 5'd6) begin
      fails++;
      $display("FAIL abort_cnt6: got cnt=%0d, want 6", cnt_out);
    end
    req = 4'b0000;
    tick();
    tests++;
    if (gnt !== 4'b0000 || cnt_out !== 5'd0 || done !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_release: got gnt=%b cnt=%0d done=%b busy=%b, want 0000 0 0000 0",
               gnt, cnt_out, done, busy);
    end
    req = 4'b0011;
    tick();
    tests++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || cnt_out !== 5'd7) begin
      fails++;
      $display("FAIL abort_regrant: got gnt=%b owner=%0d cnt=%0d, want 0001 0 7", gnt, owner, cnt_out);
    end
  endtask

  // Reset at cnt=4 clears everything; afterwards req=1111 grants 0 first.
  task automatic test_reset_mid_run();
    do_reset();
    set_val(0, 5'd6);
    req = 4'b1111;
    repeat (3) tick();
    tests++;
    if (cnt_out !== 5'd4 || gnt !== 4'b0001) begin
      fails++;
      $display("FAIL midreset_cnt4: got cnt=%0d gnt=%b, want 4 0001", cnt_out, gnt);
    end
    reset = 1'b1;
    tick();
    tests++;
    if ({gnt, done, cnt_out, owner, busy} !== '0) begin
      fails++;
      $display("FAIL midreset_clear: got gnt=%b done=%b cnt=%0d owner=%0d busy=%b, want all 0",
               gnt, done, cnt_out, owner, busy);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      fails++;
      $display("FAIL midreset_regrant: got gnt=%b owner=%0d, want 0001 0", gnt, owner);
    end
    req = '0;
    do_reset();
  endtask

`ifdef CNT_ARB_HOLD_EN
  // val 4 with hold high for 2 cycles at cnt=2: done 2 cycles later than V=4.
  task automatic test_hold();
    logic [WIDTH-1:0] exp_cnt [7];
    logic             exp_hold [7];
    exp_cnt  = '{5'd4, 5'd3, 5'd2, 5'd2, 5'd2, 5'd1, 5'd0};
    exp_hold = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    set_val(0, 5'd4);
    req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      tick();
      hold = exp_hold[c];
      tests++;
      if (cnt_out !== exp_cnt[c] || done !== ((c == 6) ? 4'b0001 : 4'b0000)) begin
        fails++;
        $display("FAIL hold_cycle%0d: got cnt=%0d done=%b, want cnt=%0d done=%b",
                 c, cnt_out, done, exp_cnt[c], (c == 6) ? 4'b0001 : 4'b0000);
      end
    end
    req = '0;
    hold = 1'b0;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1; hold = 1'b0; req = '0; req_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_load();
    test_abort();
    test_reset_mid_run();
`ifdef CNT_ARB_HOLD_EN
    test_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnt_share_arbiter.md
CNT_SHARE_ARBITER -- requirements
Module: cnt_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the counter (2..8).
REQ-002 Parameter WIDTH, default 5, width of the shared down-counter and of each load value.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request level; bit i high = requester i wants a count run.
REQ-006 req_val  input  NREQ*WIDTH  load values; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 gnt  output  NREQ  one-hot grant, registered; high for the owner for the whole run.
REQ-008 done  output  NREQ  one-cycle pulse to the owner when its count reaches zero.
REQ-009 cnt_out  output  WIDTH  current shared counter value, registered.
REQ-010 owner  output  clog2(NREQ)  index of the current or last owner.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-013 In IDLE with req nonzero, the winner SHALL be the first set bit searched from ptr+1 upward, modulo NREQ.
REQ-014 The grant edge SHALL do all of the following together:
- gnt[w]=1;
- owner=w;
- ptr=w;
- cnt_out=req_val slice w, captured only at this edge.
REQ-015 If the captured value is nonzero, the next state SHALL be COUNT; if it is zero, the next state SHALL be DONE.
REQ-016 In COUNT, cnt_out SHALL decrement by 1 per cycle. The edge that takes it from 1 to 0 SHALL also move the FSM to DONE.
REQ-017 In DONE:
- done[owner]=1 for exactly one cycle;
- gnt is still held;
- the next state SHALL be IDLE, with gnt cleared.
REQ-018 For a load value V, done SHALL assert exactly V cycles after the first cycle gnt is high. For V=0 this is the same cycle.
REQ-019 Abort: if req[owner] is low in any COUNT cycle, the next edge SHALL give IDLE, gnt=0 and cnt_out=0. No done pulse SHALL be produced, and ptr stays at the aborted owner.
REQ-020 req SHALL be ignored in DONE. A requester still high in the IDLE cycle that follows is re-arbitrated with normal round-robin priority.
REQ-021 Requests arriving during COUNT or DONE SHALL wait. There is no preemption, and no back-to-back grant without one IDLE cycle between runs.
REQ-022 Arithmetic SHALL be unsigned WIDTH bits. The counter SHALL never wrap below 0.
REQ-023 cnt_out SHALL hold its value in IDLE.

Reset
REQ-024 When reset is high at an edge, the block SHALL take all of the following values regardless of state:
- state=IDLE;
- gnt=0, done=0, cnt_out=0, owner=0, busy=0;
- ptr=NREQ-1, so that requester 0 has first priority.
REQ-025 Reset asserted mid-run SHALL drop gnt on the next edge with no done pulse. Reset SHALL take precedence over every other event.

Configuration
REQ-026 Macro CNT_ARB_HOLD_EN SHALL control whether an extra input port `hold` (1 bit) exists.
REQ-027 With CNT_ARB_HOLD_EN defined:
- `hold` is present;
- hold=1 in COUNT freezes cnt_out and the state;
- abort per REQ-019 still takes priority over hold;
- hold has no effect in IDLE or DONE.
REQ-028 Without CNT_ARB_HOLD_EN, the port SHALL be absent and the behaviour SHALL be as if hold=0.

Verification
REQ-029 After reset, drive req=0001 with val0=3 → all of the following:
- gnt=0001 next cycle;
- cnt_out=3,2,1,0;
- done=0001 in the cycle with cnt_out=0;
- busy low the cycle after.
REQ-030 Drive req=1111 continuously with all vals=1 → grant order 0,1,2,3,0, each run 2 cycles plus one IDLE cycle.
REQ-031 Drive req=0100 with val2=0 → gnt=0100 and done=0100 in the same cycle, cnt_out=0, then IDLE.
REQ-032 Grant requester 1 with val=10, then drop req[1] while cnt_out=6 → next cycle gnt=0, cnt_out=0, no done; with req=0011, grant goes to 0 next.
REQ-033 Assert reset while cnt_out=4 in COUNT → next cycle all outputs 0 and ptr=NREQ-1 (req=1111 then grants 0).
REQ-034 With CNT_ARB_HOLD_EN defined, load val=4 and pulse hold for 2 cycles at cnt_out=2 → done arrives 2 cycles later than without hold.
